// File: rtl/config_mem_arbiter_pkg.sv
// Shared configuration constants and state encodings for the config memory
// arbiter. The SPI and memory blocks import the same package, so they all
// agree on the memory depth and the arbiter state names.
package config_mem_arbiter_pkg;

  localparam int CFG_ADDR_W        = 7;
  localparam int CFG_DATA_W        = 8;
  localparam int CFG_MEM_DEPTH     = 125;
  localparam int CFG_WR_STREAK_MAX = 4;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    RD_PORT0 = 1'b0,
    RD_PORT1 = 1'b1
  } rd_port_e;

endpackage

// File: rtl/config_mem_arbiter_if.sv
// Bundle of the write requester, both read requesters, the memory port and
// the status flags. The arbiter takes the slave view; requesters and the
// memory model take the master view.
interface config_mem_arbiter_if
  import config_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = CFG_ADDR_W,
  parameter int DATA_W = CFG_DATA_W
);

  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_gnt;

  logic              rd0_req;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_gnt;
  logic              rd0_rvalid;

  logic              rd1_req;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_gnt;
  logic              rd1_rvalid;

  logic [DATA_W-1:0] rd_data;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic              addr_err;
  logic              busy;

  modport slave (
    input  wr_req, wr_addr, wr_data,
    input  rd0_req, rd0_addr, rd1_req, rd1_addr,
    input  mem_rdata,
    output wr_gnt, rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid, rd_data,
    output mem_addr, mem_wdata, mem_we, mem_re,
    output addr_err, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data,
    output rd0_req, rd0_addr, rd1_req, rd1_addr,
    output mem_rdata,
    input  wr_gnt, rd0_gnt, rd1_gnt, rd0_rvalid, rd1_rvalid, rd_data,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    input  addr_err, busy
  );

endinterface

// File: rtl/config_mem_arbiter_rr_arbiter2.sv
// Two-input round-robin picker. When both inputs request, the one that was
// not granted last wins; a lone requester always wins. The pointer only
// moves when the caller actually takes the grant.
module rr_arbiter2
  import config_mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_i,
  input  logic req1_i,
  input  logic take_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  rd_port_e last_q, last_d;

  // Pick a winner from the current requests and advance the pointer on take.
  always_comb begin
    gnt0_o = 1'b0;
    gnt1_o = 1'b0;
    last_d = last_q;
    if (req0_i && req1_i) begin
      gnt0_o = (last_q == RD_PORT1);
      gnt1_o = (last_q == RD_PORT0);
    end else begin
      gnt0_o = req0_i;
      gnt1_o = req1_i;
    end
    if (take_i && (gnt0_o || gnt1_o)) begin
      last_d = gnt1_o ? RD_PORT1 : RD_PORT0;
    end
  end

  // Pointer starts on reader 1 so reader 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= RD_PORT1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/config_mem_arbiter.sv
// Arbiter between the SPI write port and two read clients (weight fetch and
// delay fetch) sharing one single-port configuration memory. Writes go
// through in one cycle; reads take a grant cycle plus a wait cycle for the
// synchronous memory and return data on a registered bus. A write streak
// limit stops a busy SPI writer from starving the readers.
module config_mem_arbiter
  import config_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = CFG_ADDR_W,
  parameter int DATA_W        = CFG_DATA_W,
  parameter int MEM_DEPTH     = CFG_MEM_DEPTH,
  parameter int WR_STREAK_MAX = CFG_WR_STREAK_MAX
)(
  input  logic               clk,
  input  logic               reset,
  config_mem_arbiter_if.slave bus
);

  localparam int                  STREAK_W   = $clog2(WR_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_SAT = STREAK_W'(WR_STREAK_MAX);
  localparam logic [ADDR_W:0]     DEPTH_LIM  = (ADDR_W + 1)'(MEM_DEPTH);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                rd_sel_q, rd_sel_d;
  logic                rd_oor_q, rd_oor_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd0_rvalid_q, rd0_rvalid_d;
  logic                rd1_rvalid_q, rd1_rvalid_d;
  logic                addr_err_q, addr_err_d;

  logic rd_pending;
  logic wr_in_range;
  logic rd0_in_range;
  logic rd1_in_range;
  logic rr_gnt0;
  logic rr_gnt1;
  logic rd_take;

  assign rd_pending   = bus.rd0_req | bus.rd1_req;
  assign wr_in_range  = ({1'b0, bus.wr_addr}  < DEPTH_LIM);
  assign rd0_in_range = ({1'b0, bus.rd0_addr} < DEPTH_LIM);
  assign rd1_in_range = ({1'b0, bus.rd1_addr} < DEPTH_LIM);

  rr_arbiter2 u_rr (
    .clk    (clk),
    .reset  (reset),
    .req0_i (bus.rd0_req),
    .req1_i (bus.rd1_req),
    .take_i (rd_take),
    .gnt0_o (rr_gnt0),
    .gnt1_o (rr_gnt1)
  );

  // Grant selection, memory port drive and next-state for the arbiter.
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    rd_sel_d      = rd_sel_q;
    rd_oor_d      = rd_oor_q;
    rd_data_d     = rd_data_q;
    rd0_rvalid_d  = 1'b0;
    rd1_rvalid_d  = 1'b0;
    addr_err_d    = addr_err_q;
    rd_take       = 1'b0;
    bus.wr_gnt    = 1'b0;
    bus.rd0_gnt   = 1'b0;
    bus.rd1_gnt   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_addr  = bus.wr_addr;
    bus.mem_wdata = bus.wr_data;

    unique case (state_q)
      ARB_IDLE: begin
        if (bus.wr_req && !(rd_pending && (streak_q == STREAK_SAT))) begin
          bus.wr_gnt = 1'b1;
          bus.mem_we = wr_in_range;
          if (!wr_in_range) begin
            addr_err_d = 1'b1;
          end
          if (!rd_pending) begin
            streak_d = '0;
          end else if (streak_q != STREAK_SAT) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (rd_pending) begin
          rd_take  = 1'b1;
          streak_d = '0;
          state_d  = ARB_RD_WAIT;
          rd_sel_d = rr_gnt1;
          if (rr_gnt1) begin
            bus.rd1_gnt  = 1'b1;
            bus.mem_addr = bus.rd1_addr;
            bus.mem_re   = rd1_in_range;
            rd_oor_d     = !rd1_in_range;
            if (!rd1_in_range) begin
              addr_err_d = 1'b1;
            end
          end else begin
            bus.rd0_gnt  = 1'b1;
            bus.mem_addr = bus.rd0_addr;
            bus.mem_re   = rd0_in_range;
            rd_oor_d     = !rd0_in_range;
            if (!rd0_in_range) begin
              addr_err_d = 1'b1;
            end
          end
        end else begin
          streak_d = '0;
        end
      end

      ARB_RD_WAIT: begin
        rd_data_d    = rd_oor_q ? '0 : bus.mem_rdata;
        rd0_rvalid_d = !rd_sel_q;
        rd1_rvalid_d = rd_sel_q;
        state_d      = ARB_IDLE;
        if (!rd_pending) begin
          streak_d = '0;
        end
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, streak counter, in-flight read bookkeeping and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      streak_q     <= '0;
      rd_sel_q     <= 1'b0;
      rd_oor_q     <= 1'b0;
      rd_data_q    <= '0;
      rd0_rvalid_q <= 1'b0;
      rd1_rvalid_q <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      rd_sel_q     <= rd_sel_d;
      rd_oor_q     <= rd_oor_d;
      rd_data_q    <= rd_data_d;
      rd0_rvalid_q <= rd0_rvalid_d;
      rd1_rvalid_q <= rd1_rvalid_d;
      addr_err_q   <= addr_err_d;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd0_rvalid = rd0_rvalid_q;
  assign bus.rd1_rvalid = rd1_rvalid_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_config_mem_arbiter.sv
// Bench for config_mem_arbiter: directed scenarios for the key behaviours,
// then a randomized run checked against a transaction-level model of the
// arbitration rules with its own copy of the memory contents.
module tb_config_mem_arbiter;
  import config_mem_arbiter_pkg::*;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 125;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  config_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  config_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .WR_STREAK_MAX(SMAX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous memory model: write on mem_we, read data valid next cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // Control bits: {wr_gnt, rd0_gnt, rd1_gnt, mem_we, mem_re, rd0_rvalid, rd1_rvalid, busy, addr_err}
  function automatic logic [8:0] get_ctl();
    return {bus.wr_gnt, bus.rd0_gnt, bus.rd1_gnt, bus.mem_we, bus.mem_re,
            bus.rd0_rvalid, bus.rd1_rvalid, bus.busy, bus.addr_err};
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return AW'($urandom_range(DEPTH, (1<<AW)-1));
    return AW'($urandom_range(0, DEPTH-1));
  endfunction

  task automatic clear_reqs();
    bus.wr_req  = 1'b0;
    bus.rd0_req = 1'b0;
    bus.rd1_req = 1'b0;
  endtask

  task automatic do_reset();
    clear_reqs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_reqs();
    reset = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (get_ctl() !== 9'b0) begin
      bad++; $display("[TB] FAIL reset_ctl got=%b want=%b", get_ctl(), 9'b0);
    end
    total++;
    if (bus.rd_data !== 8'h00) begin
      bad++; $display("[TB] FAIL reset_rd_data got=%h want=00", bus.rd_data);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (get_ctl() !== 9'b0) begin
      bad++; $display("[TB] FAIL post_reset_ctl got=%b want=%b", get_ctl(), 9'b0);
    end
  endtask

  task automatic test_write_basic();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 7'h03;
    bus.wr_data = 8'hA5;
    #1;
    total++;
    if (get_ctl() !== 9'b100100000) begin
      bad++; $display("[TB] FAIL write_ctl got=%b want=%b", get_ctl(), 9'b100100000);
    end
    total++;
    if (bus.mem_addr !== 7'h03 || bus.mem_wdata !== 8'hA5) begin
      bad++; $display("[TB] FAIL write_port got=%h/%h want=03/a5", bus.mem_addr, bus.mem_wdata);
    end
    @(negedge clk);
    clear_reqs();
    #1;
    total++;
    if (get_ctl() !== 9'b0 || mem[3] !== 8'hA5) begin
      bad++; $display("[TB] FAIL write_after got=%b mem=%h want=%b mem=a5", get_ctl(), mem[3], 9'b0);
    end
  endtask

  task automatic test_read_basic();
    @(negedge clk);
    bus.rd0_req  = 1'b1;
    bus.rd0_addr = 7'h10;
    #1;
    total++;
    if (get_ctl() !== 9'b010010000 || bus.mem_addr !== 7'h10) begin
      bad++; $display("[TB] FAIL read_grant got=%b addr=%h want=%b addr=10", get_ctl(), bus.mem_addr, 9'b010010000);
    end
    @(negedge clk);
    clear_reqs();
    #1;
    total++;
    if (get_ctl() !== 9'b000000010) begin
      bad++; $display("[TB] FAIL read_wait got=%b want=%b", get_ctl(), 9'b000000010);
    end
    @(negedge clk);
    #1;
    total++;
    if (get_ctl() !== 9'b000001000 || bus.rd_data !== 8'h5C) begin
      bad++; $display("[TB] FAIL read_rvalid got=%b data=%h want=%b data=5c", get_ctl(), bus.rd_data, 9'b000001000);
    end
  endtask

  task automatic test_rr_alternate();
    logic [1:0] got, want;
    do_reset();
    bus.rd0_req  = 1'b1;
    bus.rd0_addr = 7'h01;
    bus.rd1_req  = 1'b1;
    bus.rd1_addr = 7'h02;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got  = {bus.rd0_gnt, bus.rd1_gnt};
      want = (k % 2 == 1) ? 2'b00 : (((k / 2) % 2 == 0) ? 2'b10 : 2'b01);
      total++;
      if (got !== want) begin
        bad++; $display("[TB] FAIL rr_cycle%0d got=%b want=%b", k, got, want);
      end
    end
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic test_streak();
    logic [1:0] got, want;
    do_reset();
    bus.wr_req   = 1'b1;
    bus.wr_addr  = 7'h21;
    bus.wr_data  = 8'h3C;
    bus.rd1_req  = 1'b1;
    bus.rd1_addr = 7'h22;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      got  = {bus.wr_gnt, bus.rd1_gnt};
      want = (k % 6 < 4) ? 2'b10 : ((k % 6 == 4) ? 2'b01 : 2'b00);
      total++;
      if (got !== want) begin
        bad++; $display("[TB] FAIL streak_cycle%0d got=%b want=%b", k, got, want);
      end
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    do_reset();
    bus.wr_req  = 1'b1;
    bus.wr_addr = 7'h7D;
    bus.wr_data = 8'h11;
    #1;
    total++;
    if (get_ctl() !== 9'b100000000) begin
      bad++; $display("[TB] FAIL oor_write got=%b want=%b", get_ctl(), 9'b100000000);
    end
    @(negedge clk);
    clear_reqs();
    #1;
    total++;
    if (get_ctl() !== 9'b000000001) begin
      bad++; $display("[TB] FAIL oor_err_set got=%b want=%b", get_ctl(), 9'b000000001);
    end
    bus.rd0_req  = 1'b1;
    bus.rd0_addr = 7'h10;
    @(negedge clk);
    bus.rd0_req = 1'b0;
    @(negedge clk);
    bus.rd0_req  = 1'b1;
    bus.rd0_addr = 7'h7F;
    #1;
    total++;
    if (get_ctl() !== 9'b010001001 || bus.rd_data !== 8'h5C) begin
      bad++; $display("[TB] FAIL oor_read_grant got=%b data=%h want=%b data=5c", get_ctl(), bus.rd_data, 9'b010001001);
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    total++;
    if (get_ctl() !== 9'b000001001 || bus.rd_data !== 8'h00) begin
      bad++; $display("[TB] FAIL oor_read_data got=%b data=%h want=%b data=00", get_ctl(), bus.rd_data, 9'b000001001);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    bus.rd1_req  = 1'b1;
    bus.rd1_addr = 7'h10;
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    total++;
    if (bus.rd_data !== 8'h5C || bus.rd1_rvalid !== 1'b1) begin
      bad++; $display("[TB] FAIL rw_preload data=%h rv=%b want=5c/1", bus.rd_data, bus.rd1_rvalid);
    end
    bus.rd1_req = 1'b1;
    #1;
    total++;
    if (bus.rd1_gnt !== 1'b1) begin
      bad++; $display("[TB] FAIL rw_grant got=%b want=1", bus.rd1_gnt);
    end
    @(negedge clk);
    clear_reqs();
    reset = 1'b1;
    #1;
    total++;
    if (get_ctl() !== 9'b0 || bus.rd_data !== 8'h00) begin
      bad++; $display("[TB] FAIL rw_reset got=%b data=%h want=%b data=00", get_ctl(), bus.rd_data, 9'b0);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++;
      if (get_ctl() !== 9'b0) begin
        bad++; $display("[TB] FAIL rw_no_rvalid%0d got=%b want=%b", k, get_ctl(), 9'b0);
      end
    end
    @(negedge clk);
    bus.rd0_req  = 1'b1;
    bus.rd0_addr = 7'h10;
    #1;
    total++;
    if (get_ctl() !== 9'b010010000) begin
      bad++; $display("[TB] FAIL rw_next_grant got=%b want=%b", get_ctl(), 9'b010010000);
    end
    @(negedge clk);
    clear_reqs();
    @(negedge clk);
    #1;
    total++;
    if (get_ctl() !== 9'b000001000 || bus.rd_data !== 8'h5C) begin
      bad++; $display("[TB] FAIL rw_next_data got=%b data=%h want=%b data=5c", get_ctl(), bus.rd_data, 9'b000001000);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] mmem [0:(1<<AW)-1];
    logic [AW-1:0] w_addr, r0_addr, r1_addr, g_addr;
    logic [DW-1:0] w_data, rv_data, exp_rd_data;
    logic [8:0]    exp_ctl;
    bit w_act, r0_act, r1_act, rp, in_wait, was_wait, exp_err;
    bit e_wg, e_r0g, e_r1g, e_we, e_re, e_rv0, e_rv1;
    int streak, last, sel, rv_due, rv_rd;

    do_reset();
    for (int i = 0; i < (1<<AW); i++) mmem[i] = mem[i];
    streak = 0; last = 1; rv_due = -1; rv_rd = 0; rv_data = '0;
    exp_rd_data = '0; in_wait = 0; exp_err = 0;
    w_act = 0; r0_act = 0; r1_act = 0;
    w_addr = '0; r0_addr = '0; r1_addr = '0; w_data = '0; sel = 0;

    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!w_act && $urandom_range(0, 2) == 0) begin
        w_act = 1; w_addr = rand_addr(); w_data = DW'($urandom);
      end
      if (!r0_act && $urandom_range(0, 1) == 0) begin
        r0_act = 1; r0_addr = rand_addr();
      end
      if (!r1_act && $urandom_range(0, 1) == 0) begin
        r1_act = 1; r1_addr = rand_addr();
      end
      bus.wr_req = w_act;  bus.wr_addr = w_addr;  bus.wr_data = w_data;
      bus.rd0_req = r0_act; bus.rd0_addr = r0_addr;
      bus.rd1_req = r1_act; bus.rd1_addr = r1_addr;
      #1;

      rp = r0_act || r1_act;
      e_wg = 0; e_r0g = 0; e_r1g = 0; e_we = 0; e_re = 0; g_addr = '0;
      if (!in_wait) begin
        if (w_act && !(rp && streak == SMAX)) begin
          e_wg = 1; g_addr = w_addr; e_we = (w_addr < DEPTH);
        end else if (rp) begin
          if (r0_act && r1_act) sel = 1 - last;
          else sel = r1_act ? 1 : 0;
          e_r0g = (sel == 0); e_r1g = (sel == 1);
          g_addr = sel ? r1_addr : r0_addr;
          e_re = (g_addr < DEPTH);
        end
      end
      e_rv0 = (rv_due == cyc) && (rv_rd == 0);
      e_rv1 = (rv_due == cyc) && (rv_rd == 1);
      if (rv_due == cyc) exp_rd_data = rv_data;
      exp_ctl = {e_wg, e_r0g, e_r1g, e_we, e_re, e_rv0, e_rv1, in_wait, exp_err};

      total++;
      if (get_ctl() !== exp_ctl) begin
        bad++; $display("[TB] FAIL rand_ctl cyc=%0d got=%b want=%b", cyc, get_ctl(), exp_ctl);
      end
      if (e_we || e_re) begin
        total++;
        if (bus.mem_addr !== g_addr) begin
          bad++; $display("[TB] FAIL rand_addr cyc=%0d got=%h want=%h", cyc, bus.mem_addr, g_addr);
        end
      end
      if (e_we) begin
        total++;
        if (bus.mem_wdata !== w_data) begin
          bad++; $display("[TB] FAIL rand_wdata cyc=%0d got=%h want=%h", cyc, bus.mem_wdata, w_data);
        end
      end
      total++;
      if (bus.rd_data !== exp_rd_data) begin
        bad++; $display("[TB] FAIL rand_rd_data cyc=%0d got=%h want=%h", cyc, bus.rd_data, exp_rd_data);
      end

      was_wait = in_wait;
      in_wait = 0;
      if (e_wg) begin
        streak = rp ? ((streak < SMAX) ? streak + 1 : SMAX) : 0;
        if (w_addr < DEPTH) mmem[w_addr] = w_data;
        else exp_err = 1;
        w_act = 0;
      end else if (e_r0g || e_r1g) begin
        streak = 0;
        last = sel;
        in_wait = 1;
        rv_due = cyc + 2;
        rv_rd = sel;
        rv_data = (g_addr < DEPTH) ? mmem[g_addr] : '0;
        if (g_addr >= DEPTH) exp_err = 1;
        if (sel == 1) r1_act = 0; else r0_act = 0;
      end else if (!rp || was_wait) begin
        if (!rp) streak = 0;
      end
      @(negedge clk);
    end
    clear_reqs();
  endtask

  initial begin
    reset = 1'b1;
    clear_reqs();
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd0_addr = '0;
    bus.rd1_addr = '0;
    for (int i = 0; i < (1<<AW); i++) mem[i] = DW'($urandom);
    mem[16] = 8'h5C;
    $display("[TB] starting config_mem_arbiter bench");
    test_reset();
    test_write_basic();
    test_read_basic();
    test_rr_alternate();
    test_streak();
    test_out_of_range();
    test_reset_in_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
